// File: rtl/shift_operand_stage.sv
// Operand-2 resolution stage feeding the execute barrel shifter.
// Resolves the three operand-2 forms into registered shifter inputs behind a valid/ready handshake.
module shift_operand_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 6,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_imm_op2,
    input  logic [7:0]             in_imm8,
    input  logic [3:0]             in_rot4,
    input  logic [DATA_WIDTH-1:0]  in_rm_data,
    input  logic                   in_shift_by_reg,
    input  logic [4:0]             in_shift_imm5,
    input  logic [1:0]             in_shift_type,
    input  logic [3:0]             in_rs_addr,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic                   flag_c,
    output logic                   rs_rd_en,
    output logic [3:0]             rs_rd_addr,
    input  logic [DATA_WIDTH-1:0]  rs_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  sh_din,
    output logic [SHAMT_WIDTH-1:0] sh_shamt,
    output logic [1:0]             sh_type,
    output logic                   sh_cin,
    output logic                   sh_is_imm,
    output logic [TAG_WIDTH-1:0]   sh_tag
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RS_WAIT = 2'd1;
    localparam logic [1:0] RS_LOAD = 2'd2;
    localparam logic [1:0] SH_ROR  = 2'b11;

    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [DATA_WIDTH-1:0]  rm_r;
    logic [1:0]             type_r;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic [SHAMT_WIDTH-1:0] shamt_hold_r;

    logic                   out_valid_r;
    logic [DATA_WIDTH-1:0]  sh_din_r;
    logic [SHAMT_WIDTH-1:0] sh_shamt_r;
    logic [1:0]             sh_type_r;
    logic                   sh_cin_r;
    logic                   sh_is_imm_r;
    logic [TAG_WIDTH-1:0]   sh_tag_r;

    logic                   slot_free_s;
    logic                   accept_s;
    logic                   load_s;
    logic                   capture_s;
    logic [DATA_WIDTH-1:0]  ld_din_s;
    logic [SHAMT_WIDTH-1:0] ld_shamt_s;
    logic [1:0]             ld_type_s;
    logic                   ld_is_imm_s;
    logic [TAG_WIDTH-1:0]   ld_tag_s;
    logic [SHAMT_WIDTH-1:0] rs_shamt_s;
    logic                   unused_rs_hi_s;

    // Only Rs[7:0] matters; shifts saturate at 63 and rotates fold to 1..32.
    function automatic logic [5:0] reg_shamt(input logic [7:0] r, input logic [1:0] t);
        logic [5:0] amt;
        if (t == SH_ROR) begin
            if (r == 8'd0) begin
                amt = 6'd0;
            end else if (r[4:0] == 5'd0) begin
                amt = 6'd32;
            end else begin
                amt = {1'b0, r[4:0]};
            end
        end else begin
            if (r > 8'd63) begin
                amt = 6'd63;
            end else begin
                amt = r[5:0];
            end
        end
        return amt;
    endfunction

    assign slot_free_s    = !out_valid_r || out_ready;
    assign in_ready       = (state_r == IDLE) && !flush && slot_free_s;
    assign accept_s       = in_valid && in_ready;
    assign rs_rd_en       = accept_s && !in_imm_op2 && in_shift_by_reg && !rst;
    assign rs_rd_addr     = rs_rd_en ? in_rs_addr : 4'd0;
    assign rs_shamt_s     = SHAMT_WIDTH'(reg_shamt(rs_rd_data[7:0], type_r));
    assign unused_rs_hi_s = ^rs_rd_data[DATA_WIDTH-1:8];

    // Next-state and output-register load selection.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        capture_s   = 1'b0;
        ld_din_s    = rm_r;
        ld_shamt_s  = rs_shamt_s;
        ld_type_s   = type_r;
        ld_is_imm_s = 1'b0;
        ld_tag_s    = tag_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        ld_tag_s = in_tag;
                        if (in_imm_op2) begin
                            load_s      = 1'b1;
                            ld_din_s    = DATA_WIDTH'(in_imm8);
                            ld_shamt_s  = SHAMT_WIDTH'({in_rot4, 1'b0});
                            ld_type_s   = SH_ROR;
                            ld_is_imm_s = 1'b0;
                        end else if (!in_shift_by_reg) begin
                            load_s      = 1'b1;
                            ld_din_s    = in_rm_data;
                            ld_shamt_s  = SHAMT_WIDTH'(in_shift_imm5);
                            ld_type_s   = in_shift_type;
                            ld_is_imm_s = 1'b1;
                        end else begin
                            state_nxt_s = RS_WAIT;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RS_WAIT: begin
                    if (slot_free_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        capture_s   = 1'b1;
                        state_nxt_s = RS_LOAD;
                    end
                end
                RS_LOAD: begin
                    ld_shamt_s = shamt_hold_r;
                    if (slot_free_s) begin
                        load_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RS_LOAD;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Control state plus the register-shift operands held while Rs is read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            rm_r         <= {DATA_WIDTH{1'b0}};
            type_r       <= 2'b00;
            tag_r        <= {TAG_WIDTH{1'b0}};
            shamt_hold_r <= {SHAMT_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (rs_rd_en) begin
                rm_r   <= in_rm_data;
                type_r <= in_shift_type;
                tag_r  <= in_tag;
            end
            if (capture_s) begin
                shamt_hold_r <= rs_shamt_s;
            end
        end
    end

    // Output slot: flush wins over a load, a load wins over a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sh_din_r    <= {DATA_WIDTH{1'b0}};
            sh_shamt_r  <= {SHAMT_WIDTH{1'b0}};
            sh_type_r   <= 2'b00;
            sh_cin_r    <= 1'b0;
            sh_is_imm_r <= 1'b0;
            sh_tag_r    <= {TAG_WIDTH{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            sh_din_r    <= ld_din_s;
            sh_shamt_r  <= ld_shamt_s;
            sh_type_r   <= ld_type_s;
            sh_cin_r    <= flag_c;
            sh_is_imm_r <= ld_is_imm_s;
            sh_tag_r    <= ld_tag_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign sh_din    = sh_din_r;
    assign sh_shamt  = sh_shamt_r;
    assign sh_type   = sh_type_r;
    assign sh_cin    = sh_cin_r;
    assign sh_is_imm = sh_is_imm_r;
    assign sh_tag    = sh_tag_r;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Self-checking bench for shift_operand_stage: directed vectors, corner sequences,
// and randomized traffic scored against an operand-2 reference model.
module tb_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_imm_op2;
    logic [7:0]  in_imm8;
    logic [3:0]  in_rot4;
    logic [31:0] in_rm_data;
    logic        in_shift_by_reg;
    logic [4:0]  in_shift_imm5;
    logic [1:0]  in_shift_type;
    logic [3:0]  in_rs_addr;
    logic [7:0]  in_tag;
    logic        flag_c;
    logic        rs_rd_en;
    logic [3:0]  rs_rd_addr;
    logic [31:0] rs_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sh_din;
    logic [5:0]  sh_shamt;
    logic [1:0]  sh_type;
    logic        sh_cin;
    logic        sh_is_imm;
    logic [7:0]  sh_tag;

    shift_operand_stage #(.DATA_WIDTH(32), .SHAMT_WIDTH(6), .TAG_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm_op2(in_imm_op2), .in_imm8(in_imm8), .in_rot4(in_rot4),
        .in_rm_data(in_rm_data), .in_shift_by_reg(in_shift_by_reg),
        .in_shift_imm5(in_shift_imm5), .in_shift_type(in_shift_type),
        .in_rs_addr(in_rs_addr), .in_tag(in_tag), .flag_c(flag_c),
        .rs_rd_en(rs_rd_en), .rs_rd_addr(rs_rd_addr), .rs_rd_data(rs_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .sh_din(sh_din), .sh_shamt(sh_shamt), .sh_type(sh_type),
        .sh_cin(sh_cin), .sh_is_imm(sh_is_imm), .sh_tag(sh_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        imm_op2;
        logic [7:0]  imm8;
        logic [3:0]  rot4;
        logic [31:0] rm;
        logic        by_reg;
        logic [4:0]  imm5;
        logic [1:0]  stype;
        logic [3:0]  rs_addr;
        logic [31:0] rs_val;
        logic        fc;
        logic [31:0] exp_din;
        logic [5:0]  exp_shamt;
        logic [1:0]  exp_type;
        logic        exp_is_imm;
        int          exp_lat;
    } vec_t;

    logic [31:0] regfile [16];
    logic [49:0] sb_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  tag_ctr  = 8'h80;

    // Synchronous register-file read port; unrelated cycles return noise.
    always @(posedge clk) begin
        rs_rd_data <= rs_rd_en ? regfile[rs_rd_addr] : $urandom();
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ARM operand-2 rules stated arithmetically.
    function automatic logic [49:0] model(input vec_t o, input logic [31:0] rs,
                                          input logic fc, input logic [7:0] tag);
        logic [31:0] din;
        int          amt;
        logic [1:0]  typ;
        logic        isi;
        int          r;
        if (o.imm_op2) begin
            din = 32'(o.imm8);
            amt = int'(o.rot4) * 2;
            typ = 2'd3;
            isi = 1'b0;
        end else if (!o.by_reg) begin
            din = o.rm;
            amt = int'(o.imm5);
            typ = o.stype;
            isi = 1'b1;
        end else begin
            din = o.rm;
            typ = o.stype;
            isi = 1'b0;
            r   = int'(rs[7:0]);
            if (o.stype == 2'd3) begin
                amt = (r == 0) ? 0 : (((r % 32) == 0) ? 32 : (r % 32));
            end else begin
                amt = (r > 63) ? 63 : r;
            end
        end
        return {din, 6'(amt), typ, fc, isi, tag};
    endfunction

    task automatic drive_op(input vec_t v, input logic [7:0] tag);
        in_imm_op2      = v.imm_op2;
        in_imm8         = v.imm8;
        in_rot4         = v.rot4;
        in_rm_data      = v.rm;
        in_shift_by_reg = v.by_reg;
        in_shift_imm5   = v.imm5;
        in_shift_type   = v.stype;
        in_rs_addr      = v.rs_addr;
        in_tag          = tag;
        flag_c          = v.fc;
    endtask

    // Starts just after a rising edge with the stage idle and empty.
    task automatic run_vec(input vec_t v, input logic [7:0] tag);
        int lat;
        regfile[v.rs_addr] = v.rs_val;
        drive_op(v, tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("in_ready_idle", 64'(in_ready), 64'(1'b1));
        check("rd_en_accept", 64'(rs_rd_en), 64'(v.by_reg && !v.imm_op2));
        if (v.by_reg && !v.imm_op2) begin
            check("rd_addr", 64'(rs_rd_addr), 64'(v.rs_addr));
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
            if (lat == 1) begin
                check("rd_en_pulse", 64'(rs_rd_en), 64'(1'b0));
            end
        end while (!out_valid && lat < 5);
        check("latency", 64'(lat), 64'(v.exp_lat));
        check("result", 64'({sh_din, sh_shamt, sh_type, sh_cin, sh_is_imm, sh_tag}),
              64'({v.exp_din, v.exp_shamt, v.exp_type, v.fc, v.exp_is_imm, tag}));
        @(posedge clk); #1;
        check("drain", 64'(out_valid), 64'(1'b0));
    endtask

    task automatic rand_step(input bit issue, input logic fc);
        vec_t o;
        @(posedge clk); #1;
        o.imm_op2 = ($urandom % 3 == 0);
        o.imm8    = 8'($urandom);
        o.rot4    = 4'($urandom);
        o.rm      = $urandom;
        o.by_reg  = 1'($urandom);
        o.imm5    = 5'($urandom);
        o.stype   = 2'($urandom);
        o.rs_addr = 4'($urandom);
        o.rs_val  = 32'd0;
        o.fc      = fc;
        if (issue && ($urandom % 2 == 0)) begin
            drive_op(o, tag_ctr);
            in_valid = 1'b1;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = issue ? ($urandom % 4 != 0) : 1'b1;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: output tag %0h with no expected op", sh_tag);
            end else begin
                check("sb_out", 64'({sh_din, sh_shamt, sh_type, sh_cin, sh_is_imm, sh_tag}),
                      64'(sb_q.pop_front()));
            end
        end
        if (in_valid && in_ready) begin
            sb_q.push_back(model(o, regfile[o.rs_addr], fc, tag_ctr));
            tag_ctr++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [12];
        vec_t v;
        logic fc;
        vecs[0]  = '{1'b1, 8'hFF, 4'd4, 32'h0,        1'b0, 5'd0,  2'd0, 4'd0,  32'h0,        1'b0, 32'h000000FF, 6'd8,  2'd3, 1'b0, 1};
        vecs[1]  = '{1'b0, 8'h00, 4'd0, 32'h80000001, 1'b0, 5'd0,  2'd1, 4'd0,  32'h0,        1'b1, 32'h80000001, 6'd0,  2'd1, 1'b1, 1};
        vecs[2]  = '{1'b0, 8'h00, 4'd0, 32'h12345678, 1'b1, 5'd0,  2'd0, 4'd3,  32'h100,      1'b0, 32'h12345678, 6'd0,  2'd0, 1'b0, 2};
        vecs[3]  = '{1'b0, 8'h00, 4'd0, 32'hDEADBEEF, 1'b1, 5'd0,  2'd1, 4'd5,  32'h45,       1'b1, 32'hDEADBEEF, 6'd63, 2'd1, 1'b0, 2};
        vecs[4]  = '{1'b0, 8'h00, 4'd0, 32'h0F0F0F0F, 1'b1, 5'd0,  2'd3, 4'd7,  32'h40,       1'b0, 32'h0F0F0F0F, 6'd32, 2'd3, 1'b0, 2};
        vecs[5]  = '{1'b0, 8'h00, 4'd0, 32'hA5A5A5A5, 1'b1, 5'd0,  2'd3, 4'd15, 32'h21,       1'b1, 32'hA5A5A5A5, 6'd1,  2'd3, 1'b0, 2};
        vecs[6]  = '{1'b1, 8'h5A, 4'd0, 32'h77777777, 1'b1, 5'd9,  2'd1, 4'd6,  32'h0,        1'b1, 32'h0000005A, 6'd0,  2'd3, 1'b0, 1};
        vecs[7]  = '{1'b0, 8'h00, 4'd0, 32'hF0000000, 1'b0, 5'd31, 2'd2, 4'd0,  32'h0,        1'b0, 32'hF0000000, 6'd31, 2'd2, 1'b1, 1};
        vecs[8]  = '{1'b0, 8'h00, 4'd0, 32'h11111111, 1'b1, 5'd0,  2'd2, 4'd1,  32'h1FF,      1'b1, 32'h11111111, 6'd63, 2'd2, 1'b0, 2};
        vecs[9]  = '{1'b0, 8'h00, 4'd0, 32'h22222222, 1'b1, 5'd0,  2'd3, 4'd0,  32'hFFFFFF00, 1'b0, 32'h22222222, 6'd0,  2'd3, 1'b0, 2};
        vecs[10] = '{1'b0, 8'h00, 4'd0, 32'h33333333, 1'b1, 5'd0,  2'd0, 4'd4,  32'h40,       1'b1, 32'h33333333, 6'd63, 2'd0, 1'b0, 2};
        vecs[11] = '{1'b0, 8'h00, 4'd0, 32'h44444444, 1'b1, 5'd0,  2'd3, 4'd8,  32'h3F,       1'b0, 32'h44444444, 6'd31, 2'd3, 1'b0, 2};

        for (int i = 0; i < 16; i++) begin
            regfile[i] = 32'(i) * 32'h01010100;
        end

        // Reset: outputs cleared and no read request even with a register op presented.
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        drive_op(vecs[2], 8'h00);
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_outputs", 64'({sh_din, sh_shamt, sh_type, sh_cin, sh_is_imm, sh_tag}), 64'(0));
        check("rst_rd_en", 64'(rs_rd_en), 64'(1'b0));
        check("rst_rd_addr", 64'(rs_rd_addr), 64'(4'd0));
        in_valid = 1'b0;
        #10 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], 8'(i));
        end

        // Backpressure on a register shift: output holds, upstream stalls, then back-to-back handoff.
        v = vecs[2];
        v.rs_addr = 4'd9; v.rs_val = 32'h00000025; v.rm = 32'hCAFEBABE; v.fc = 1'b1;
        regfile[9] = v.rs_val;
        drive_op(v, 8'h40);
        in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("bp_rd_en", 64'({rs_rd_en, rs_rd_addr}), 64'({1'b1, 4'd9}));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_wait_ready", 64'(in_ready), 64'(1'b0));
        check("bp_wait_valid", 64'(out_valid), 64'(1'b0));
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check("bp_hold", 64'({out_valid, in_ready, sh_din, sh_shamt, sh_cin, sh_tag}),
                  64'({1'b1, 1'b0, 32'hCAFEBABE, 6'd37, 1'b1, 8'h40}));
            @(posedge clk); #1;
        end
        drive_op(vecs[0], 8'h41);
        in_imm8 = 8'h3C; in_rot4 = 4'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp_ready_up", 64'(in_ready), 64'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_next", 64'({out_valid, sh_din, sh_shamt, sh_tag}),
              64'({1'b1, 32'h0000003C, 6'd2, 8'h41}));
        @(posedge clk); #1;
        check("bp_empty", 64'(out_valid), 64'(1'b0));

        // Streaming: four immediates, one per cycle, tags in order.
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                check("stream", 64'({out_valid, sh_tag}), 64'({1'b1, 8'(8'h10 + k - 1)}));
            end
            if (k < 4) begin
                drive_op(vecs[0], 8'(8'h10 + k));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("stream_end", 64'(out_valid), 64'(1'b0));

        // Flush while waiting on Rs, then flush while idle with a request presented.
        regfile[2] = 32'h21;
        v = vecs[5]; v.rs_addr = 4'd2;
        drive_op(v, 8'h50);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        check("flush_rd_en_wait", 64'({rs_rd_en, in_ready}), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_no_valid", 64'(out_valid), 64'(1'b0));
        @(posedge clk); #1;
        check("flush_idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        flush = 1'b1; in_valid = 1'b1;
        #1;
        check("flush_rd_en_idle", 64'({rs_rd_en, rs_rd_addr, in_ready}), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("flush_no_accept", 64'(out_valid), 64'(1'b0));
        run_vec(vecs[0], 8'h52);

        // Asynchronous reset while waiting on Rs.
        drive_op(vecs[3], 8'h60);
        regfile[vecs[3].rs_addr] = vecs[3].rs_val;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_clear", 64'({out_valid, sh_din, sh_shamt, sh_tag, rs_rd_en}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("arst_no_valid", 64'(out_valid), 64'(1'b0));
        end
        run_vec(vecs[1], 8'h61);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 16; i++) begin
            regfile[i] = {24'($urandom), (($urandom % 3 == 0) ? 8'($urandom) : 8'($urandom_range(0, 70)))};
        end
        for (int seg = 0; seg < 4; seg++) begin
            fc = 1'($urandom);
            for (int c = 0; c < 50; c++) begin
                rand_step(1'b1, fc);
            end
            for (int c = 0; c < 6; c++) begin
                rand_step(1'b0, fc);
            end
            check("sb_drained", 64'(sb_q.size()), 64'(0));
            sb_q.delete();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
